vc_fifo_bank: RTL and testbench

Parametrised multi-channel virtual-channel FIFO bank: NUM_VC independent FIFOs sharing one storage array, one write port and one read port, each selected by a channel ID. It generalises the single-channel VC FIFO with these additions:
- programmable depth, width and channel count
- per-channel occupancy outputs
- hysteretic pause (flow control)
- sticky, clearable error flags
- registered read data with a valid strobe

It sits between the input demux and the VC arbiter/mux of the data path.

---
 rtl/vc_fifo_bank.sv | 118 +++++++++++
 tb/tb_vc_fifo_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_bank.sv
// Multi-channel virtual-channel FIFO bank: NUM_VC independent FIFOs sharing
// one storage array, one write port and one read port.
module vc_fifo_bank #(
  parameter int DATA_SIZE  = 6,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_VC     = 2,
  parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CW         = DEPTH_LOG2 + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [VC_W-1:0]        push_vc,
  input  logic [DATA_SIZE-1:0]   data_in,
  input  logic                   pop,
  input  logic [VC_W-1:0]        pop_vc,
  input  logic [CW-1:0]          af_thresh,
  input  logic [CW-1:0]          ae_thresh,
  input  logic [NUM_VC-1:0]      err_clr,
  output logic [DATA_SIZE-1:0]   data_out,
  output logic                   data_valid,
  output logic [NUM_VC-1:0]      empty,
  output logic [NUM_VC-1:0]      full,
  output logic [NUM_VC-1:0]      almost_full,
  output logic [NUM_VC-1:0]      almost_empty,
  output logic [NUM_VC-1:0]      pause,
  output logic [NUM_VC-1:0]      error,
  output logic [NUM_VC*CW-1:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int AW    = VC_W + DEPTH_LOG2;

  logic [DATA_SIZE-1:0]  mem [NUM_VC*DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr [NUM_VC];
  logic [DEPTH_LOG2-1:0] rd_ptr [NUM_VC];
  logic [CW-1:0]         cnt [NUM_VC];
  logic [CW-1:0]         cnt_nxt [NUM_VC];
  logic [NUM_VC-1:0]     push_ok, pop_ok, err_set, pause_nxt;
  logic [AW-1:0]         wr_addr, rd_addr;

  // Per-channel acceptance, error events, next occupancy and next pause.
  // Out-of-range channel IDs match no channel, so they are silently ignored.
  always_comb begin
    push_ok   = '0;
    pop_ok    = '0;
    err_set   = '0;
    pause_nxt = '0;
    wr_addr   = '0;
    rd_addr   = '0;
    cnt_nxt   = '{default: '0};
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      pop_ok[i]  = pop && (pop_vc == VC_W'(i)) && (cnt[i] != '0);
      // A full channel still accepts a push when it is popped in the same cycle.
      push_ok[i] = push && (push_vc == VC_W'(i)) &&
                   ((cnt[i] != CW'(DEPTH)) || pop_ok[i]);
      err_set[i] = (push && (push_vc == VC_W'(i)) && !push_ok[i]) ||
                   (pop  && (pop_vc  == VC_W'(i)) && !pop_ok[i]);
      cnt_nxt[i] = cnt[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
      if (cnt_nxt[i] >= af_thresh)
        pause_nxt[i] = 1'b1;
      else if (cnt_nxt[i] <= ae_thresh)
        pause_nxt[i] = 1'b0;
      else
        pause_nxt[i] = pause[i];
      if (push_ok[i]) wr_addr = {VC_W'(i), wr_ptr[i]};
      if (pop_ok[i])  rd_addr = {VC_W'(i), rd_ptr[i]};
    end
  end

  // Shared storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (|push_ok) mem[wr_addr] <= data_in;
  end

  // Pointers, counts, pause, sticky errors and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      pause      <= '0;
      error      <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt_nxt[i];
      end
      pause      <= pause_nxt;
      // A new error event outranks a coincident clear.
      error      <= err_set | (error & ~err_clr);
      data_valid <= |pop_ok;
      if (|pop_ok) data_out <= mem[rd_addr];
    end
  end

  // Combinational status flags and flattened occupancy.
  always_comb begin
    empty        = '0;
    full         = '0;
    almost_full  = '0;
    almost_empty = '0;
    count        = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      empty[i]          = (cnt[i] == '0);
      full[i]           = (cnt[i] == CW'(DEPTH));
      almost_full[i]    = (cnt[i] >= af_thresh);
      almost_empty[i]   = (cnt[i] <= ae_thresh) && (cnt[i] != '0);
      count[i*CW +: CW] = cnt[i];
    end
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank with queue-based reference model.
module tb_vc_fifo_bank;

  logic       clk, reset, push, pop;
  logic [0:0] push_vc, pop_vc;
  logic [5:0] data_in, data_out;
  logic [4:0] af_thresh, ae_thresh;
  logic [1:0] err_clr;
  logic       data_valid;
  logic [1:0] empty, full, almost_full, almost_empty, pause, error;
  logic [9:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus sticky/registered outputs.
  logic [5:0] q [2][$];
  logic [1:0] m_err, m_pause;
  logic       m_dv;
  logic [5:0] m_dout;

  vc_fifo_bank #(.DATA_SIZE(6), .DEPTH_LOG2(4), .NUM_VC(2)) dut (
    .clk(clk), .reset(reset), .push(push), .push_vc(push_vc), .data_in(data_in),
    .pop(pop), .pop_vc(pop_vc), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .pause(pause), .error(error), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [28:0] obs;
  assign obs = {count, empty, full, almost_full, almost_empty, pause, error,
                data_valid, data_out};

  function automatic logic [28:0] exp_obs();
    logic [9:0] c;
    logic [1:0] e, f, a, ae;
    for (int v = 0; v < 2; v++) begin
      c[v*5 +: 5] = 5'(q[v].size());
      e[v]  = (q[v].size() == 0);
      f[v]  = (q[v].size() == 16);
      a[v]  = (q[v].size() >= int'(af_thresh));
      ae[v] = (q[v].size() <= int'(ae_thresh)) && (q[v].size() != 0);
    end
    return {c, e, f, a, ae, m_pause, m_err, m_dv, m_dout};
  endfunction

  // Drive one cycle of stimulus, advance the model, and settle past the edge.
  task automatic cycle(input bit ps, input int pv, input logic [5:0] d,
                       input bit pp, input int ov, input logic [1:0] clr);
    bit pok [2];
    bit uok [2];
    bit any;
    logic [5:0] popped;
    push = ps; push_vc = 1'(pv); data_in = d;
    pop = pp; pop_vc = 1'(ov); err_clr = clr;
    popped = '0;
    if (reset) begin
      q[0].delete(); q[1].delete();
      m_err = '0; m_pause = '0; m_dv = 1'b0; m_dout = '0;
    end else begin
      any = 1'b0;
      for (int v = 0; v < 2; v++) pok[v] = pp && (ov == v) && (q[v].size() > 0);
      for (int v = 0; v < 2; v++) uok[v] = ps && (pv == v) && ((q[v].size() < 16) || pok[v]);
      for (int v = 0; v < 2; v++) begin
        if (pok[v]) begin popped = q[v].pop_front(); any = 1'b1; end
        if (uok[v]) q[v].push_back(d);
        if ((ps && pv == v && !uok[v]) || (pp && ov == v && !pok[v])) m_err[v] = 1'b1;
        else if (clr[v]) m_err[v] = 1'b0;
        if (q[v].size() >= int'(af_thresh)) m_pause[v] = 1'b1;
        else if (q[v].size() <= int'(ae_thresh)) m_pause[v] = 1'b0;
      end
      m_dv = any;
      if (any) m_dout = popped;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== exp_obs()) begin
      errors++; $display("FAIL reset_model: got %h expected %h", obs, exp_obs());
    end
    checks++;
    if ({count, empty, pause, error, data_valid} !== {10'd0, 2'b11, 2'b00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got count=%h empty=%b pause=%b error=%b dv=%b expected 0,11,00,00,0",
               count, empty, pause, error, data_valid);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 1, 6'(i), 0, 0, 2'b00);
      checks++;
      if (obs !== exp_obs()) begin
        errors++; $display("FAIL fill_push%0d: got %h expected %h", i, obs, exp_obs());
      end
    end
    checks++;
    if (full[1] !== 1'b1 || count[9:5] !== 5'd16) begin
      errors++; $display("FAIL fill_full: got full=%b count1=%0d expected 1,16", full[1], count[9:5]);
    end
    cycle(1, 1, 6'h3F, 0, 0, 2'b00);
    checks++;
    if (error[1] !== 1'b1 || count[9:5] !== 5'd16) begin
      errors++; $display("FAIL overflow: got error=%b count1=%0d expected 1,16", error[1], count[9:5]);
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, '0, 1, 1, 2'b00);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 6'(i) || obs !== exp_obs()) begin
        errors++;
        $display("FAIL drain_pop%0d: got dv=%b data=%h expected 1,%h", i, data_valid, data_out, 6'(i));
      end
    end
    cycle(0, 0, '0, 1, 1, 2'b00);
    checks++;
    if (data_valid !== 1'b0 || obs !== exp_obs()) begin
      errors++; $display("FAIL underflow_pop: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_isolation();
    do_reset();
    cycle(1, 0, 6'h0A, 0, 0, 2'b00);
    cycle(1, 1, 6'h15, 0, 0, 2'b00);
    cycle(0, 0, '0, 1, 1, 2'b00);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 6'h15) begin
      errors++; $display("FAIL iso_vc1: got dv=%b data=%h expected 1,15", data_valid, data_out);
    end
    cycle(0, 0, '0, 1, 0, 2'b00);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 6'h0A) begin
      errors++; $display("FAIL iso_vc0: got dv=%b data=%h expected 1,0a", data_valid, data_out);
    end
    cycle(1, 1, 6'h22, 0, 0, 2'b00);
    cycle(1, 0, 6'h2B, 1, 1, 2'b00);
    checks++;
    if (count !== {5'd0, 5'd1} || data_out !== 6'h22 || obs !== exp_obs()) begin
      errors++; $display("FAIL iso_cross: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_hysteresis();
    af_thresh = 5'd12; ae_thresh = 5'd4;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 0, 6'(i), 0, 0, 2'b00);
      checks++;
      if (pause[0] !== (i >= 12) || obs !== exp_obs()) begin
        errors++; $display("FAIL hyst_fill%0d: got pause=%b expected %b", i, pause[0], (i >= 12));
      end
    end
    for (int n = 11; n >= 3; n--) begin
      cycle(0, 0, '0, 1, 0, 2'b00);
      checks++;
      if (pause[0] !== (n > 4) || obs !== exp_obs()) begin
        errors++; $display("FAIL hyst_drain%0d: got pause=%b expected %b", n, pause[0], (n > 4));
      end
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 1, 6'(i + 32), 0, 0, 2'b00);
    cycle(1, 1, 6'h3E, 1, 1, 2'b00);
    checks++;
    if (count[9:5] !== 5'd16 || error[1] !== 1'b0 || data_out !== 6'd32 || data_valid !== 1'b1) begin
      errors++; $display("FAIL full_pushpop: got count1=%0d err=%b data=%h expected 16,0,20",
                         count[9:5], error[1], data_out);
    end
    cycle(1, 0, 6'h11, 1, 0, 2'b00);
    checks++;
    if (count[4:0] !== 5'd1 || error[0] !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL empty_pushpop: got count0=%0d err=%b dv=%b expected 1,1,0",
                         count[4:0], error[0], data_valid);
    end
    cycle(0, 0, '0, 0, 0, 2'b01);
    checks++;
    if (error !== 2'b00 || obs !== exp_obs()) begin
      errors++; $display("FAIL err_clr: got error=%b expected 00", error);
    end
    cycle(0, 0, '0, 1, 0, 2'b00);
    cycle(0, 0, '0, 1, 0, 2'b01);
    checks++;
    if (error[0] !== 1'b1 || obs !== exp_obs()) begin
      errors++; $display("FAIL clr_vs_set: got error=%b expected 1", error[0]);
    end
    // Remaining ordered contents of VC1 after the full push+pop.
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, '0, 1, 1, 2'b00);
      checks++;
      if (obs !== exp_obs()) begin
        errors++; $display("FAIL bnd_drain%0d: got %h expected %h", i, obs, exp_obs());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 6'(i + 1), 0, 0, 2'b00);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 6'(i + 4), 1, 0, 2'b00);
      checks++;
      if (data_out !== 6'(i + 1) || count[4:0] !== 5'd3 || error !== 2'b00 || obs !== exp_obs()) begin
        errors++; $display("FAIL wrap%0d: got data=%h count0=%0d err=%b expected %h,3,00",
                           i, data_out, count[4:0], error, 6'(i + 1));
      end
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      af_thresh = 5'($urandom_range(0, 16));
      ae_thresh = 5'($urandom_range(0, 16));
      do_reset();
      for (int i = 0; i < 150; i++) begin
        cycle(($urandom_range(0, 99) < 60), int'($urandom_range(0, 1)), 6'($urandom),
              ($urandom_range(0, 99) < 45), int'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00);
        checks++;
        if (obs !== exp_obs()) begin
          errors++; $display("FAIL random_s%0d_c%0d: got %h expected %h", seg, i, obs, exp_obs());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    af_thresh = 5'd12; ae_thresh = 5'd4;
    for (int i = 0; i < 20; i++) cycle(1, i % 2, 6'(i), (i > 4), (i + 1) % 2, 2'b00);
    cycle(0, 0, '0, 1, 0, 2'b00);
    do_reset();
    checks++;
    if (obs !== exp_obs() || count !== 10'd0 || empty !== 2'b11 || data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", obs, exp_obs());
    end
    cycle(0, 0, '0, 1, 1, 2'b00);
    checks++;
    if (data_valid !== 1'b0 || error !== 2'b10) begin
      errors++; $display("FAIL reset_mid_pop: got dv=%b err=%b expected 0,10", data_valid, error);
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_vc = '0; pop_vc = '0;
    data_in = '0; err_clr = '0; af_thresh = 5'd12; ae_thresh = 5'd4;
    m_err = '0; m_pause = '0; m_dv = 1'b0; m_dout = '0;
    test_reset();
    test_fill_drain();
    test_isolation();
    test_hysteresis();
    test_boundaries();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
